// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// Merges N_CH packet sources onto one downstream stream. An internal arbiter
// picks one channel per cycle (round-robin or fixed priority), holds the
// grant for the whole packet, and the chosen beat is captured in a single
// registered output stage.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   fixed_prio  1 = lowest valid index wins, 0 = round-robin (used while unlocked)
//   in_valid    per-channel beat valid
//   in_data     channel i at [i*WIDTH +: WIDTH]
//   in_last     per-channel end-of-packet flag
//   in_ready    per-channel accept, one-hot or zero
//   out_valid   output register holds a beat
//   out_data    registered beat data
//   out_last    registered end-of-packet flag
//   out_ch      source channel of the held beat
//   out_ready   downstream accept
module stream_mux_rr #(
  parameter int N_CH    = 4,
  parameter int WIDTH   = 8,
  parameter int SLICE_W = 2,
  localparam int CW     = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fixed_prio,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_last,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_last,
  output logic [CW-1:0]         out_ch,
  input  logic                  out_ready
);

  localparam int NSL = WIDTH / SLICE_W;

  typedef enum logic {
    S_UNLOCKED = 1'b0,
    S_LOCKED   = 1'b1
  } state_t;

  state_t            state;
  logic [CW-1:0]     lock_ch;
  logic [CW-1:0]     rr_ptr;

  logic              load;
  logic              gnt_found;
  logic [CW-1:0]     gnt_ch;
  logic [CW-1:0]     next_ptr;
  logic              xfer;
  logic [2*N_CH-1:0] dbl_valid;
  logic [2*N_CH-1:0] shifted;
  logic [N_CH-1:0]   rot_valid;
  logic [CW:0]       rr_sum;
  logic [WIDTH-1:0]  sel_data;
  logic              sel_last;

  logic [SLICE_W-1:0] slices [NSL][N_CH];

  // The output register may take a new beat when it is empty or being drained.
  assign load = !out_valid || out_ready;

  // Arbiter. While locked only the packet owner is a candidate. Unlocked,
  // fixed priority scans upward from 0; round-robin rotates the valid vector
  // so that rr_ptr sits at bit 0, finds the first set bit, then maps the
  // offset back to a channel index modulo N_CH. Loops run downward so the
  // lowest qualifying index is the last assignment and wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_ch    = '0;
    rr_sum    = '0;
    dbl_valid = {in_valid, in_valid};
    shifted   = dbl_valid >> rr_ptr;
    rot_valid = shifted[N_CH-1:0];
    if (state == S_LOCKED) begin
      if (in_valid[lock_ch]) begin
        gnt_found = 1'b1;
        gnt_ch    = lock_ch;
      end
    end else if (fixed_prio) begin
      for (int i = N_CH-1; i >= 0; i--) begin
        if (in_valid[i]) begin
          gnt_found = 1'b1;
          gnt_ch    = CW'(i);
        end
      end
    end else begin
      for (int k = N_CH-1; k >= 0; k--) begin
        if (rot_valid[k]) begin
          rr_sum = {1'b0, rr_ptr} + (CW+1)'(k);
          if (rr_sum >= (CW+1)'(N_CH)) begin
            rr_sum = rr_sum - (CW+1)'(N_CH);
          end
          gnt_found = 1'b1;
          gnt_ch    = rr_sum[CW-1:0];
        end
      end
    end
  end

  // Only the granted channel sees ready, and nobody does while in reset or
  // while the output register is stalled.
  always_comb begin
    in_ready = '0;
    if (rst_n && load && gnt_found) begin
      in_ready[gnt_ch] = 1'b1;
    end
  end

  assign xfer = gnt_found && load;

  // Pointer moves just past the channel that finished a packet.
  always_comb begin
    if (gnt_ch == CW'(N_CH-1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = gnt_ch + CW'(1);
    end
  end

  // Data path: every SLICE_W-bit slice is a narrow N_CH:1 mux sharing the
  // same select, slice 0 landing in the least significant position.
  for (genvar s = 0; s < NSL; s++) begin : g_slice
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign slices[s][c] = in_data[c*WIDTH + s*SLICE_W +: SLICE_W];
    end
    assign sel_data[s*SLICE_W +: SLICE_W] = slices[s][gnt_ch];
  end

  assign sel_last = in_last[gnt_ch];

  // Output register, lock state and round-robin pointer. A transfer loads
  // the beat and either releases (last) or takes (not last) the lock; with
  // no transfer a drained register simply goes empty. Reset wipes all of it,
  // including any packet in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_UNLOCKED;
      lock_ch   <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_ch    <= gnt_ch;
      if (sel_last) begin
        state  <= S_UNLOCKED;
        rr_ptr <= next_ptr;
      end else begin
        state   <= S_LOCKED;
        lock_ch <= gnt_ch;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
// Directed bench for stream_mux_rr. A packet-level model of the arbiter and
// output register runs alongside the default 4x8 instance and is compared
// every cycle; literal expectations along the directed sequence pin the model.
// A second 3-channel, 12-bit instance covers the non-power-of-two wrap and
// wider slices.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;
  logic        fixed_prio;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_last;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic [1:0]  out_ch;
  logic        out_ready;

  logic        b_rst_n;
  logic [2:0]  b_in_valid;
  logic [35:0] b_in_data;
  logic [2:0]  b_in_last;
  logic [2:0]  b_in_ready;
  logic        b_out_valid;
  logic [11:0] b_out_data;
  logic        b_out_last;
  logic [1:0]  b_out_ch;
  logic        b_out_ready;

  integer assertCount = 0;
  integer failCount   = 0;

  stream_mux_rr #(.N_CH(4), .WIDTH(8), .SLICE_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .fixed_prio(fixed_prio),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready)
  );

  stream_mux_rr #(.N_CH(3), .WIDTH(12), .SLICE_W(4)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .fixed_prio(1'b0),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_last(b_in_last),
    .in_ready(b_in_ready), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_last(b_out_last), .out_ch(b_out_ch), .out_ready(b_out_ready)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertCount = assertCount + 1;
    if (actual !== expected) begin
      failCount = failCount + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [3:0] last,
                               input logic [31:0] data, input logic fixed,
                               input logic oready);
    in_valid   = valid;
    in_last    = last;
    in_data    = data;
    fixed_prio = fixed;
    out_ready  = oready;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Packet-level model: which channel should be granted this cycle, and what
  // the output register should hold. Round-robin order is "first valid when
  // counting up from the pointer, modulo 4".
  bit         m_live   = 0;
  bit         m_locked = 0;
  bit         m_valid  = 0;
  bit         m_last   = 0;
  int         m_ptr    = 0;
  int         m_lock   = 0;
  int         m_ch     = 0;
  logic [7:0] m_data   = 8'h00;

  initial begin : compare
    int         gnt;
    bit         ld;
    bit         rst_s;
    bit         ordy_s;
    logic [7:0] g_data;
    bit         g_last;
    logic [3:0] exp_ready;
    forever begin
      @(negedge clk);
      rst_s  = rst_n;
      ordy_s = out_ready;
      ld     = !m_valid || ordy_s;
      gnt    = -1;
      g_data = 8'h00;
      g_last = 1'b0;
      if (rst_s && ld) begin
        if (m_locked) begin
          if (in_valid[m_lock]) gnt = m_lock;
        end else begin
          for (int k = 0; k < 4; k++) begin
            int c;
            c = fixed_prio ? k : (m_ptr + k) % 4;
            if (gnt < 0 && in_valid[c]) gnt = c;
          end
        end
      end
      exp_ready = 4'b0000;
      if (gnt >= 0) begin
        exp_ready[gnt] = 1'b1;
        g_data = in_data[gnt*8 +: 8];
        g_last = in_last[gnt];
      end
      if (m_live) begin
        checkOutput("model in_ready", {28'd0, in_ready}, {28'd0, exp_ready});
        checkOutput("model out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        checkOutput("model out_data", {24'd0, out_data}, {24'd0, m_data});
        checkOutput("model out_last", {31'd0, out_last}, {31'd0, m_last});
        checkOutput("model out_ch", {30'd0, out_ch}, 32'(m_ch));
      end
      @(posedge clk);
      if (!rst_s) begin
        m_live = 1; m_locked = 0; m_valid = 0; m_last = 0;
        m_ptr = 0; m_lock = 0; m_ch = 0; m_data = 8'h00;
      end else if (gnt >= 0) begin
        m_valid = 1; m_data = g_data; m_last = g_last; m_ch = gnt;
        if (g_last) begin
          m_locked = 0;
          m_ptr    = (gnt + 1) % 4;
        end else begin
          m_locked = 1;
          m_lock   = gnt;
        end
      end else if (ordy_s) begin
        m_valid = 0;
      end
    end
  end

  // Directed sequence with literal expectations.
  initial begin : stimulus
    int seq [5];
    seq = '{0, 1, 2, 3, 0};
    rst_n = 1'b0;
    b_rst_n = 1'b0;
    b_in_valid = 3'b000; b_in_last = 3'b000; b_in_data = 36'd0; b_out_ready = 1'b1;
    applyStimulus(4'b1111, 4'b1111, 32'h03020100, 1'b0, 1'b1);

    // Reset: nothing accepted even with every channel valid.
    @(negedge clk);
    checkOutput("ready in reset", {28'd0, in_ready}, 32'h0);
    tick;
    tick;
    checkOutput("out_valid after reset", {31'd0, out_valid}, 32'h0);
    checkOutput("out_ch after reset", {30'd0, out_ch}, 32'h0);

    // Round-robin, single-beat packets on all channels.
    rst_n = 1'b1;
    applyStimulus(4'b1111, 4'b1111, 32'hC3C2C1C0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("rr first ready", {28'd0, in_ready}, 32'h1);
    checkOutput("rr out_valid before xfer", {31'd0, out_valid}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("rr out_ch seq", {30'd0, out_ch}, 32'(seq[k]));
      checkOutput("rr out_valid", {31'd0, out_valid}, 32'h1);
    end

    // Fixed priority with channels 1 and 3 valid: channel 3 starves.
    tick;
    applyStimulus(4'b1010, 4'b1111, 32'hC3C2C1C0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("fixed ready", {28'd0, in_ready}, 32'h2);
    tick;
    tick;
    @(negedge clk);
    checkOutput("fixed out_ch", {30'd0, out_ch}, 32'h1);
    checkOutput("fixed ready held", {28'd0, in_ready}, 32'h2);

    // Three-beat packet on channel 2, channel 0 valid throughout.
    tick;
    applyStimulus(4'b0101, 4'b0001, 32'h0011000F, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("pkt beat1 ready", {28'd0, in_ready}, 32'h4);
    tick;
    applyStimulus(4'b0101, 4'b0001, 32'h0022000F, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("pkt beat1 data", {24'd0, out_data}, 32'h11);
    checkOutput("pkt beat1 ch", {30'd0, out_ch}, 32'h2);
    checkOutput("pkt locked ready", {28'd0, in_ready}, 32'h4);
    tick;
    applyStimulus(4'b0001, 4'b0001, 32'h0022000F, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("pkt owner idle ready", {28'd0, in_ready}, 32'h0);
    checkOutput("pkt beat2 data", {24'd0, out_data}, 32'h22);
    tick;
    applyStimulus(4'b0101, 4'b0101, 32'h0033000F, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("pkt drained valid", {31'd0, out_valid}, 32'h0);
    checkOutput("pkt beat3 ready", {28'd0, in_ready}, 32'h4);
    tick;
    applyStimulus(4'b0001, 4'b0001, 32'h0033000F, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("pkt beat3 data", {24'd0, out_data}, 32'h33);
    checkOutput("pkt beat3 last", {31'd0, out_last}, 32'h1);
    checkOutput("post pkt ready", {28'd0, in_ready}, 32'h1);
    tick;
    @(negedge clk);
    checkOutput("post pkt ch", {30'd0, out_ch}, 32'h0);

    // Back-pressure while holding 0xA5.
    tick;
    applyStimulus(4'b0001, 4'b0001, 32'h000000A5, 1'b0, 1'b1);
    tick;
    applyStimulus(4'b1111, 4'b1111, 32'h3C2B1A5A, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("stall data", {24'd0, out_data}, 32'hA5);
      checkOutput("stall ready", {28'd0, in_ready}, 32'h0);
      tick;
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("release ready", {28'd0, in_ready}, 32'h2);
    tick;
    @(negedge clk);
    checkOutput("release data", {24'd0, out_data}, 32'h1A);
    checkOutput("release ch", {30'd0, out_ch}, 32'h1);

    // Reset in the middle of a packet on channel 1.
    tick;
    applyStimulus(4'b0010, 4'b0000, 32'h00007700, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("lock ch1 ready", {28'd0, in_ready}, 32'h2);
    tick;
    rst_n = 1'b0;
    applyStimulus(4'b1111, 4'b0000, 32'h44332211, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("midpkt reset ready", {28'd0, in_ready}, 32'h0);
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midpkt reset valid", {31'd0, out_valid}, 32'h0);
    checkOutput("midpkt reset ch", {30'd0, out_ch}, 32'h0);
    checkOutput("midpkt reset grant", {28'd0, in_ready}, 32'h1);
    tick;
    @(negedge clk);
    checkOutput("after reset data", {24'd0, out_data}, 32'h11);
    tick;
    applyStimulus(4'b0000, 4'b0000, 32'h0, 1'b0, 1'b1);

    // Three channels, 12-bit data in 4-bit slices.
    b_rst_n = 1'b1;
    b_in_valid = 3'b100;
    b_in_last = 3'b111;
    b_in_data = {12'hABC, 12'h123, 12'h456};
    @(negedge clk);
    checkOutput("b ready ch2", {29'd0, b_in_ready}, 32'h4);
    tick;
    b_in_valid = 3'b111;
    @(negedge clk);
    checkOutput("b out_data", {20'd0, b_out_data}, 32'hABC);
    checkOutput("b out_ch", {30'd0, b_out_ch}, 32'h2);
    checkOutput("b wrap ready", {29'd0, b_in_ready}, 32'h1);
    tick;
    @(negedge clk);
    checkOutput("b wrap data", {20'd0, b_out_data}, 32'h456);

    tick;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes, packet locking and selectable round-robin or fixed-priority arbitration. It generalises our static 4:1 select mux. The select is generated internally by an arbiter, not supplied by the user. The data path is built from SLICE_W-bit select slices, and the result is held in a registered output stage. The block merges several packet sources onto one downstream stream.

## Interface

Parameters:
- N_CH, 4: number of input channels; legal range 2..16.
- WIDTH, 8: data width per channel; must be a multiple of SLICE_W.
- SLICE_W, 2: width of each narrow select slice in the data path; WIDTH/SLICE_W slices share one select.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- fixed_prio  input  1  1 = fixed priority (lowest index wins); 0 = round-robin. Sampled only while unlocked.
- in_valid  input  N_CH  per-channel beat valid.
- in_data  input  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_last  input  N_CH  per-channel end-of-packet flag.
- in_ready  output  N_CH  per-channel accept; one-hot or zero.
- out_valid  output  1  output register holds a beat.
- out_data  output  WIDTH  registered data.
- out_last  output  1  registered end-of-packet flag.
- out_ch  output  $clog2(N_CH)  index of the source channel for the held beat.
- out_ready  input  1  downstream accept.

## Operation

- Load enable: load = !out_valid || out_ready.
- Grant: one channel c is granted per cycle when load=1 and a candidate has in_valid=1. Only the granted channel sees in_ready[c]=1 (combinational).
- A beat transfers on a channel when in_valid[c] && in_ready[c]. On that edge the output register captures {data, last, c} and sets out_valid=1.
- out_valid clears when out_ready=1 and no input transfers in the same cycle.
- State machine:
  - UNLOCKED: the arbiter picks among all valid channels.
    - Fixed-priority mode: the lowest valid index wins.
    - Round-robin mode: the first valid index searching upward from rr_ptr, wrapping at N_CH-1 to 0.
    - A transfer with in_last=0 records lock_ch=c and moves the block to LOCKED.
    - A transfer with in_last=1 stays UNLOCKED.
  - LOCKED: only lock_ch is a candidate; all other channels see in_ready=0 even when they are valid.
    - A transfer with in_last=1 returns the block to UNLOCKED.
- rr_ptr update: on every transfer with in_last=1, rr_ptr becomes (c+1) mod N_CH, regardless of mode. Packets are never interleaved.
- fixed_prio is ignored while LOCKED and takes effect at the next UNLOCKED arbitration.
- Data path: every SLICE_W slice selects channel c's corresponding slice with the same select. The slices are concatenated with slice 0 in the least significant position.
- in_data and in_last of ungranted channels have no effect on any output.

## Timing

- Reset (rst_n=0 at an edge):
  - out_valid=0, out_data=0, out_last=0, out_ch=0.
  - rr_ptr=0, state UNLOCKED, lock_ch=0.
  - in_ready is all-zero while rst_n=0.
- Reset mid-packet discards the lock and any held beat. No state survives.
- Latency: a beat accepted at edge k appears on out_* immediately after edge k, i.e. one cycle.
- Throughput: one beat per cycle with continuous out_ready=1.
- in_ready depends combinationally on out_ready; there is no skid buffer.
- Back-pressure:
  - While out_valid=1 and out_ready=0, in_ready is all-zero.
  - The output register, state, rr_ptr and lock_ch hold.
- Simultaneous events: when out_ready=1 and a new transfer occur in the same cycle, the new beat replaces the old one and out_valid stays 1.
- A single-beat packet (in_last=1 on its first beat) never enters LOCKED.
- In LOCKED with in_valid[lock_ch]=0, no transfer occurs; the block waits indefinitely and grants no other channel.

## Test plan

- Reset, then all inputs valid in round-robin mode with in_last=1 and out_ready=1 -> out_ch sequence 0,1,2,3,0; one beat per cycle; out_valid first rises one cycle after the first transfer.
- Same stimulus in fixed-priority mode with in_valid=4'b1010 held -> every beat has out_ch=1; channel 3 starved; in_ready=4'b0010.
- Channel 2 sends a 3-beat packet (0x11, 0x22, 0x33 with last on the third beat) while channel 0 is valid throughout -> out_data 0x11, 0x22, 0x33 from ch2 uninterrupted, then ch3 (if valid) else ch0; in_ready[0]=0 during the packet.
- out_ready=0 for 3 cycles while out_valid=1 holding 0xA5 -> out_data stays 0xA5; in_ready=0; rr_ptr unchanged; the next beat is accepted on the cycle out_ready returns to 1.
- rst_n=0 for one cycle in LOCKED mid-packet on ch1 -> after the edge out_valid=0, out_ch=0, rr_ptr=0; the next grant may go to ch0.
- WIDTH=12, SLICE_W=4, N_CH=3: channel 2 sends 0xABC -> out_data=0xABC, out_ch=2; rr_ptr wraps to 0 after its last beat.
